// File: rtl/block_drawer.sv
// Rasterises a BLOCK_W x BLOCK_H block onto the VGA plot interface, one pixel per clock,
// optionally painting the previously drawn position black first.
module block_drawer #(
  parameter int BLOCK_W  = 4,
  parameter int BLOCK_H  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       erase_first,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIN} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } pix_t;

  localparam logic [4:0] DX_LAST = 5'(BLOCK_W - 1);
  localparam logic [4:0] DY_LAST = 5'(BLOCK_H - 1);

  state_t     state, state_n;
  logic [4:0] dx, dx_n, dy, dy_n;
  logic [7:0] nx, nx_n, ox, ox_n;
  logic [6:0] ny, ny_n, oy, oy_n;
  logic [2:0] ncol, ncol_n;
  logic       old_valid, old_valid_n;
  pix_t       pix, pix_n;
  logic       last;

  // Sums are one bit wider than the outputs so off-screen wrap is caught by the clip test.
  function automatic pix_t make_pix(input logic [7:0] bx, input logic [6:0] by,
                                    input logic [4:0] ix, input logic [4:0] iy,
                                    input logic [2:0] col);
    logic [8:0] sx;
    logic [7:0] sy;
    pix_t r;
    sx = {1'b0, bx} + {4'b0, ix};
    sy = {1'b0, by} + {3'b0, iy};
    r.x = sx[7:0];
    r.y = sy[6:0];
    r.c = col;
    r.p = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
    return r;
  endfunction

  assign last = (dx == DX_LAST) && (dy == DY_LAST);

  always_comb begin
    state_n     = state;
    dx_n        = dx;
    dy_n        = dy;
    nx_n        = nx;
    ny_n        = ny;
    ncol_n      = ncol;
    ox_n        = ox;
    oy_n        = oy;
    old_valid_n = old_valid;
    pix_n       = '0;
    case (state)
      IDLE: begin
        if (start) begin
          nx_n   = x_in;
          ny_n   = y_in;
          ncol_n = colour_in;
          dx_n   = '0;
          dy_n   = '0;
          if (erase_first && old_valid) begin
            state_n = ERASE;
            pix_n   = make_pix(ox, oy, 5'd0, 5'd0, 3'b000);
          end else begin
            state_n = DRAW;
            pix_n   = make_pix(x_in, y_in, 5'd0, 5'd0, colour_in);
          end
        end
      end
      ERASE, DRAW: begin
        if (last) begin
          dx_n = '0;
          dy_n = '0;
          if (state == ERASE) begin
            state_n = DRAW;
            pix_n   = make_pix(nx, ny, 5'd0, 5'd0, ncol);
          end else begin
            state_n     = FIN;
            ox_n        = nx;
            oy_n        = ny;
            old_valid_n = 1'b1;
          end
        end else begin
          // Counters always name the pixel presented on the outputs this cycle.
          if (dx == DX_LAST) begin
            dx_n = '0;
            dy_n = dy + 5'd1;
          end else begin
            dx_n = dx + 5'd1;
          end
          if (state == ERASE) pix_n = make_pix(ox, oy, dx_n, dy_n, 3'b000);
          else                pix_n = make_pix(nx, ny, dx_n, dy_n, ncol);
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dx        <= '0;
      dy        <= '0;
      nx        <= '0;
      ny        <= '0;
      ncol      <= '0;
      ox        <= '0;
      oy        <= '0;
      old_valid <= 1'b0;
      pix       <= '0;
    end else begin
      state     <= state_n;
      dx        <= dx_n;
      dy        <= dy_n;
      nx        <= nx_n;
      ny        <= ny_n;
      ncol      <= ncol_n;
      ox        <= ox_n;
      oy        <= oy_n;
      old_valid <= old_valid_n;
      pix       <= pix_n;
    end
  end

  assign vga_x      = pix.x;
  assign vga_y      = pix.y;
  assign vga_colour = pix.c;
  assign plot       = pix.p;
  assign busy       = (state == ERASE) || (state == DRAW);
  assign done       = (state == FIN);

endmodule

// File: tb/tb_block_drawer.sv
// Directed and random checks of block_drawer against a pixel-list reference model.
module tb_block_drawer;

  localparam int W = 4, H = 4, SW = 160, SH = 120;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, erase_first = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  int errors = 0, checks = 0;

  typedef struct {int x; int y; int c; bit p;} epix_t;

  // Model of the remembered position
  bit m_valid = 0;
  int m_ox = 0, m_oy = 0;

  block_drawer #(.BLOCK_W(W), .BLOCK_H(H), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset(reset), .start(start), .erase_first(erase_first),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_x"}, vga_x, 0);
    check({tag, "_y"}, vga_y, 0);
    check({tag, "_col"}, vga_colour, 0);
  endtask

  task automatic add_block(ref epix_t q[$], input int bx, input int by, input int col);
    epix_t e;
    for (int j = 0; j < H; j++)
      for (int i = 0; i < W; i++) begin
        e.x = (bx + i) % 256;
        e.y = (by + j) % 128;
        e.c = col;
        e.p = ((bx + i) < SW) && ((by + j) < SH);
        q.push_back(e);
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1 check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    m_valid = 0;
    m_ox = 0;
    m_oy = 0;
  endtask

  task automatic op(input int x, input int y, input int c, input bit ef,
                    input int pulse_at, input int rst_at);
    epix_t q[$];
    epix_t e;
    if (ef && m_valid) add_block(q, m_ox, m_oy, 0);
    add_block(q, x, y, c);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_plot", plot, 0);
    x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c); erase_first = ef;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom);
    erase_first = 1'($urandom);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      e = q[k];
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("plot", plot, 32'(e.p));
      if (e.p) begin
        check("vga_x", vga_x, e.x);
        check("vga_y", vga_y, e.y);
        check("vga_colour", vga_colour, e.c);
      end
      if (k + 1 == pulse_at) begin
        start = 1'b1;
        x_in = 8'(x ^ 8'h55);
        erase_first = 1'b1;
      end
      if (k + 1 == pulse_at + 1) start = 1'b0;
      if (k + 1 == rst_at) begin
        reset = 1'b1;
        #1 check_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        m_valid = 0;
        return;
      end
    end
    @(negedge clk);
    check("done", done, 1);
    check("done_busy", busy, 0);
    check("done_plot", plot, 0);
    m_valid = 1;
    m_ox = x;
    m_oy = y;
  endtask

  initial begin
    #1 check_zero("por");
    do_reset();
    op(8, 116, 3'b100, 0, -1, -1);
    op(12, 116, 3'b010, 1, -1, -1);
    op(158, 118, 3'b111, 0, -1, -1);
    op(250, 125, 3'b011, 1, -1, -1);
    do_reset();
    op(20, 30, 3'b101, 1, -1, -1);
    op(40, 50, 3'b011, 0, 5, -1);
    op(44, 50, 3'b110, 1, 5, -1);
    op(60, 60, 3'b001, 0, -1, 7);
    op(70, 70, 3'b110, 1, -1, -1);
    for (int n = 0; n < 40; n++)
      op(int'($urandom_range(255)), int'($urandom_range(127)), int'($urandom_range(7)),
         1'($urandom), -1, -1);
    repeat (2) @(negedge clk);
    check("final_done", done, 0);
    check("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
